// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester round-robin front end for an 8-bit add/sub unit.
// One operation is in flight at a time: IDLE accepts, EXEC computes from the
// registered operands, and RESP presents the registered result to the granted
// requester until it is taken.
module adder_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic             req_op0,
  input  logic             req_op1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic             last_reg;     // id of the most recent grant
  logic             gnt_reg;      // id owning the operation in flight
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             op_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg, ovf_reg;
  logic [CNT_W-1:0] ops_done_reg;

  logic [1:0] req_valid_vec, req_ready_vec, rsp_valid_vec, rsp_ready_vec;
  logic       any_valid, grant_id;
  logic       ready_en, resp_en, rsp_done;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_full;
  logic             ovf_calc;

  assign req_valid_vec = {req_valid1, req_valid0};
  assign rsp_ready_vec = {rsp_ready1, rsp_ready0};
  assign any_valid     = |req_valid_vec;

  // With both valid the requester that did not win last time gets the grant;
  // with one valid it wins outright.
  assign grant_id = (&req_valid_vec) ? ~last_reg : req_valid_vec[1];

  // Only the granted requester's ready may complete the response.
  assign rsp_done = resp_en && rsp_ready_vec[gnt_reg];

  // Add/sub unit: subtraction is a + ~b + 1, the +1 coming in as carry-in.
  assign b_eff    = op_reg ? ~b_reg : b_reg;
  assign sum_full = {1'b0, a_reg} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_reg};
  assign ovf_calc = (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum_full[WIDTH-1] != a_reg[WIDTH-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: accept, compute, then wait for the response handshake.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (any_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready_vec[gnt_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: accept window in IDLE (held off during reset), response in RESP.
  always_comb begin
    ready_en = 1'b0;
    resp_en  = 1'b0;
    unique case (state_reg)
      IDLE:    ready_en = !rst && any_valid;
      RESP:    resp_en  = 1'b1;
      default: begin
        ready_en = 1'b0;
        resp_en  = 1'b0;
      end
    endcase
  end

  // Per-requester handshake steering from the shared grant.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready_vec[gi] = ready_en && (grant_id == 1'(gi));
      assign rsp_valid_vec[gi] = resp_en && (gnt_reg == 1'(gi));
    end
  endgenerate

  // Operand capture on accept, result capture in EXEC, completion counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg     <= 1'b1;
      gnt_reg      <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= 1'b0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      ops_done_reg <= '0;
    end else begin
      if (ready_en) begin
        last_reg <= grant_id;
        gnt_reg  <= grant_id;
        a_reg    <= grant_id ? req_a1  : req_a0;
        b_reg    <= grant_id ? req_b1  : req_b0;
        op_reg   <= grant_id ? req_op1 : req_op0;
      end
      if (state_reg == EXEC) begin
        sum_reg  <= sum_full[WIDTH-1:0];
        cout_reg <= sum_full[WIDTH];
        ovf_reg  <= ovf_calc;
      end
      if (rsp_done) ops_done_reg <= ops_done_reg + CNT_W'(1);
    end
  end

  assign req_ready0   = req_ready_vec[0];
  assign req_ready1   = req_ready_vec[1];
  assign rsp_valid0   = rsp_valid_vec[0];
  assign rsp_valid1   = rsp_valid_vec[1];
  assign rsp_sum      = sum_reg;
  assign rsp_cout     = cout_reg;
  assign rsp_overflow = ovf_reg;
  assign ops_done     = ops_done_reg;

endmodule
